// File: rtl/fw_ram_ctrl.sv
// Firmware-only RAM with per-byte writes, application-mode access lockout and a
// hardware zeroization sweep that owns the single RAM port while it runs.
module fw_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fw_app_mode,
  input  logic                    zeroize,
  input  logic                    cs,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    ready,
  output logic                    busy,
  output logic                    access_violation
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    mode_prev_q;
  logic                    ready_q;
  logic                    viol_q;
  logic [DATA_WIDTH-1:0]   read_data_q;
  logic                    mode_rise;
  logic                    accept;

  logic [NB-1:0]           mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign mode_rise = fw_app_mode & ~mode_prev_q;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    accept     = 1'b0;
    case (state_q)
      StClear: begin
        if (mode_rise) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == '1) begin
          state_d = StIdle;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      StIdle: begin
        // A wipe request beats a bus access presented in the same cycle.
        if (mode_rise || zeroize) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end else begin
          accept = cs;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Single RAM port: the sweep owns it while clearing.
  always_comb begin
    mem_we    = '0;
    mem_addr  = address;
    mem_wdata = write_data;
    if (!reset_n) begin
      mem_we = '0;
    end else if (state_q == StClear) begin
      mem_we    = '1;
      mem_addr  = clr_addr_q;
      mem_wdata = '0;
    end else if (accept && !fw_app_mode) begin
      mem_we = we;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_we[b]) begin
        mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StClear;
      clr_addr_q  <= '0;
      mode_prev_q <= 1'b0;
      ready_q     <= 1'b0;
      viol_q      <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      mode_prev_q <= fw_app_mode;
      ready_q     <= accept;
      viol_q      <= accept & fw_app_mode;
      if (state_q == StClear) begin
        read_data_q <= '0;
      end else if (accept) begin
        if (fw_app_mode) begin
          read_data_q <= '0;
        end else if (we == '0) begin
          read_data_q <= mem[address];
        end
      end
    end
  end

  // Gate combinationally so stale data vanishes the moment a wipe starts.
  assign read_data        = (state_q == StClear) ? '0 : read_data_q;
  assign ready            = ready_q;
  assign busy             = (state_q == StClear);
  assign access_violation = viol_q;

endmodule

// File: tb/tb_fw_ram_ctrl.sv
// Directed plus randomized bench for fw_ram_ctrl (ADDR_WIDTH=4) against a
// word-array reference model of the firmware RAM contents.
module tb_fw_ram_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fw_app_mode;
  logic          zeroize;
  logic          cs;
  logic [3:0]    we;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          ready;
  logic          busy;
  logic          access_violation;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [31:0]   model [DEPTH];

  fw_ram_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fw_app_mode      (fw_app_mode),
    .zeroize          (zeroize),
    .cs               (cs),
    .we               (we),
    .address          (address),
    .write_data       (write_data),
    .read_data        (read_data),
    .ready            (ready),
    .busy             (busy),
    .access_violation (access_violation)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  // Holds cs until ready, bounded; returns latency and the completion-cycle outputs.
  task automatic access(input logic [3:0] w, input logic [AW-1:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic av);
    cs = 1'b1; we = w; address = a; write_data = d;
    lat = 0;
    do begin
      step();
      lat++;
    end while (ready !== 1'b1 && lat < 100);
    rd = read_data;
    av = access_violation;
    cs = 1'b0; we = 4'h0;
  endtask

  task automatic fw_rw(input logic [3:0] w, input logic [AW-1:0] a, input logic [31:0] d,
                       input string tag);
    int          lat;
    logic [31:0] rd, mask;
    logic        av;
    access(w, a, d, lat, rd, av);
    chk({tag, " latency"}, 32'(lat), 32'd1);
    chk({tag, " violation"}, {31'h0, av}, 32'h0);
    if (w == 4'h0) begin
      chk({tag, " read_data"}, rd, model[a]);
    end else begin
      mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
      model[a] = (model[a] & ~mask) | (d & mask);
    end
  endtask

  // Counts consecutive busy samples; optionally raises fw_app_mode after sample restart_at.
  task automatic count_busy(input int restart_at, output int n, output int early);
    n = 0; early = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (ready === 1'b1) early++;
      if (n == restart_at) fw_app_mode = 1'b1;
      step();
    end
  endtask

  initial begin
    int          n, early, lat;
    logic [31:0] rd;
    logic        av;

    reset_n = 1'b0; fw_app_mode = 1'b0; zeroize = 1'b0; cs = 1'b0;
    we = 4'h0; address = '0; write_data = '0;
    model_clear();
    step();
    step();
    chk("reset busy", {31'h0, busy}, 32'h1);
    chk("reset ready", {31'h0, ready}, 32'h0);
    chk("reset read_data", read_data, 32'h0);
    chk("reset violation", {31'h0, access_violation}, 32'h0);

    // Sweep after reset release, with a read held pending throughout.
    reset_n = 1'b1;
    cs = 1'b1; we = 4'h0; address = 4'd0;
    count_busy(0, n, early);
    chk("post-reset busy cycles", 32'(n), 32'd16);
    chk("ready during sweep", 32'(early), 32'd0);
    chk("ready as busy falls", {31'h0, ready}, 32'h0);
    step();
    chk("held cs ready", {31'h0, ready}, 32'h1);
    chk("held cs read_data", read_data, 32'h0);
    cs = 1'b0;
    for (int i = 0; i < DEPTH; i++) fw_rw(4'h0, AW'(i), 32'h0, "sweep readback");

    // Byte-lane writes.
    fw_rw(4'hF, 4'd5, 32'hAABBCCDD, "bytes wr1");
    fw_rw(4'h5, 4'd5, 32'h11223344, "bytes wr2");
    access(4'h0, 4'd5, 32'h0, lat, rd, av);
    chk("bytes latency", 32'(lat), 32'd1);
    chk("bytes merged", rd, 32'hAA22CC44);

    // Application-mode lock.
    fw_rw(4'hF, 4'd3, 32'hDEADBEEF, "lock fill");
    fw_app_mode = 1'b1;
    step();
    count_busy(0, n, early);
    model_clear();
    chk("app-mode busy cycles", 32'(n), 32'd16);
    access(4'h0, 4'd3, 32'h0, lat, rd, av);
    chk("app read latency", 32'(lat), 32'd1);
    chk("app read_data", rd, 32'h0);
    chk("app read violation", {31'h0, av}, 32'h1);
    step();
    chk("violation pulse width", {31'h0, access_violation}, 32'h0);
    access(4'hF, 4'd3, 32'h12345678, lat, rd, av);
    chk("app write violation", {31'h0, av}, 32'h1);
    fw_app_mode = 1'b0;
    step();
    chk("falling edge no sweep", {31'h0, busy}, 32'h0);
    fw_rw(4'h0, 4'd3, 32'h0, "app write blocked");

    // Zeroize beats a same-cycle access.
    fw_rw(4'hF, 4'd0, 32'h01020304, "zero fill0");
    fw_rw(4'hF, 4'd15, 32'hF0E0D0C0, "zero fill15");
    fw_rw(4'h0, 4'd15, 32'h0, "zero pre-read");
    zeroize = 1'b1; cs = 1'b1; we = 4'h0; address = 4'd0;
    step();
    zeroize = 1'b0; cs = 1'b0;
    chk("zeroize access refused", {31'h0, ready}, 32'h0);
    chk("zeroize busy", {31'h0, busy}, 32'h1);
    count_busy(0, n, early);
    model_clear();
    chk("zeroize busy cycles", 32'(n), 32'd16);
    fw_rw(4'h0, 4'd0, 32'h0, "zeroize addr0");
    fw_rw(4'h0, 4'd15, 32'h0, "zeroize addr15");

    // Mode edge restarts a running sweep.
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    count_busy(7, n, early);
    chk("restart busy cycles", 32'(n), 32'd23);
    fw_app_mode = 1'b0;
    step();

    // Randomized firmware-mode traffic.
    for (int k = 0; k < 150; k++) begin
      logic [3:0] w;
      w = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      fw_rw(w, AW'($urandom_range(0, DEPTH - 1)), $urandom, "random");
    end

    // Reset during a back-to-back read burst.
    fw_rw(4'hF, 4'd2, 32'hCAFE0002, "burst fill");
    cs = 1'b1; we = 4'h0; address = 4'd2;
    step();
    chk("burst ready 1", {31'h0, ready}, 32'h1);
    chk("burst data 1", read_data, model[2]);
    step();
    chk("burst ready 2", {31'h0, ready}, 32'h1);
    chk("burst data 2", read_data, model[2]);
    reset_n = 1'b0;
    step();
    chk("mid reset ready", {31'h0, ready}, 32'h0);
    chk("mid reset read_data", read_data, 32'h0);
    chk("mid reset busy", {31'h0, busy}, 32'h1);
    reset_n = 1'b1; cs = 1'b0;
    count_busy(0, n, early);
    model_clear();
    chk("mid reset busy cycles", 32'(n), 32'd16);
    fw_rw(4'h0, 4'd2, 32'h0, "mid reset readback");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
